// File: rtl/inst_queue.sv
// -----------------------------------------------------------------------------
// inst_queue
//
// Instruction queue between the icache and decode. Whole cache lines are
// buffered in a circular FIFO of DEPTH entries. The head entry is sliced into
// 32-bit instructions one word at a time: a fire on a non-final word moves the
// head pc on by 4 and keeps the entry, and a fire on word 15 pops the entry.
//
// Handshake: both sides use valid/ready. A transfer happens on a rising edge
// where the producer's valid and the consumer's ready are both high. The
// producer holds its payload stable until that edge. Towards the icache,
// "ready" is !stall_icache_o. A line offered while stall_icache_o is high is
// dropped, and the icache re-offers it. Towards decode, a fire is
// iq_valid_o && iq_ready_i.
//
// Parameters
//   DEPTH      number of line entries (power of two, >= 2)
//   LINE_SIZE  line width in bits (512 = 16 x 32-bit words)
//
// Ports
//   clk, rst_n         clock (rising edge), asynchronous active-low reset
//   icache_valid_i     line offered by icache
//   icache_pc_i        fetch pc of the line (bits [1:0] ignored)
//   icache_data_i      line data
//   stall_icache_o     queue full; offered lines are not taken
//   squash_pipe_i      backend flush; empties the queue at the next edge
//   iq_valid_o         instruction presented to decode
//   iq_ready_i         decode accepts the presented instruction
//   iq_pc_o, iq_inst_o pc and instruction word at the head
//   perf_inst_cnt_o    instructions delivered
//   perf_stall_cnt_o   cycles spent with stall_icache_o high
//
// Optional feature: define INST_QUEUE_PERF_EN to build the two performance
// counters. Without it both perf ports are constant 0.
// -----------------------------------------------------------------------------
module inst_queue #(
   parameter int DEPTH     = 4,
   parameter int LINE_SIZE = 512
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 icache_valid_i,
   input  logic [63:0]          icache_pc_i,
   input  logic [LINE_SIZE-1:0] icache_data_i,
   output logic                 stall_icache_o,
   input  logic                 squash_pipe_i,
   output logic                 iq_valid_o,
   input  logic                 iq_ready_i,
   output logic [63:0]          iq_pc_o,
   output logic [31:0]          iq_inst_o,
   output logic [63:0]          perf_inst_cnt_o,
   output logic [63:0]          perf_stall_cnt_o
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;
   localparam int WORDS = LINE_SIZE / 32;
   localparam int IDX_W = $clog2(WORDS);

   logic [63:0]          pc_mem   [DEPTH];
   logic [LINE_SIZE-1:0] line_mem [DEPTH];
   logic [PTR_W-1:0]     rd_ptr;
   logic [PTR_W-1:0]     wr_ptr;
   logic [CNT_W-1:0]     count;

   logic [63:0]          head_pc;
   logic [IDX_W-1:0]     head_idx;
   logic                 head_last;
   logic                 full;
   logic                 push;
   logic                 fire;
   logic                 pop;
   logic                 advance;

   // The low pc bits are forced to zero on entry, so the input bits are dropped.
   logic                 unused_pc_bits;
   assign unused_pc_bits = ^icache_pc_i[1:0];

   // Status depends on the registered count only, so there is no
   // combinational path from any input to the stall output.
   assign full           = (count == CNT_W'(DEPTH));
   assign stall_icache_o = full;
   assign iq_valid_o     = (count != '0);

   assign head_pc   = pc_mem[rd_ptr];
   assign head_idx  = head_pc[IDX_W+1:2];
   assign head_last = (head_idx == {IDX_W{1'b1}});

   assign iq_pc_o   = head_pc;
   assign iq_inst_o = line_mem[rd_ptr][32*head_idx +: 32];

   // Squash overrides any push, pop or pc advance in the same cycle.
   assign fire    = iq_valid_o && iq_ready_i;
   assign push    = icache_valid_i && !full && !squash_pipe_i;
   assign pop     = fire && head_last && !squash_pipe_i;
   assign advance = fire && !head_last && !squash_pipe_i;

   // Pointers and occupancy. DEPTH is a power of two, so the pointers wrap
   // naturally when they overflow.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
      end else if (squash_pipe_i) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + PTR_W'(1);
         if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
         case ({push, pop})
            2'b10:   count <= count + CNT_W'(1);
            2'b01:   count <= count - CNT_W'(1);
            default: count <= count;
         endcase
      end
   end

   // Entry pcs. A push and an advance never hit the same slot. A push needs
   // the queue not full, and an advance needs it not empty, so the write slot
   // differs from the head slot whenever both happen.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < DEPTH; i++) pc_mem[i] <= '0;
      end else begin
         if (push)    pc_mem[wr_ptr] <= {icache_pc_i[63:2], 2'b00};
         if (advance) pc_mem[rd_ptr] <= head_pc + 64'd4;
      end
   end

   // Line data is only read from occupied slots, so it carries no reset.
   always_ff @(posedge clk) begin
      if (push) line_mem[wr_ptr] <= icache_data_i;
   end

`ifdef INST_QUEUE_PERF_EN
   logic [63:0] inst_cnt;
   logic [63:0] stall_cnt;

   // Counters survive squash; only reset clears them. They wrap at 2^64.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         inst_cnt  <= '0;
         stall_cnt <= '0;
      end else begin
         if (fire) inst_cnt  <= inst_cnt + 64'd1;
         if (full) stall_cnt <= stall_cnt + 64'd1;
      end
   end

   assign perf_inst_cnt_o  = inst_cnt;
   assign perf_stall_cnt_o = stall_cnt;
`else
   assign perf_inst_cnt_o  = 64'd0;
   assign perf_stall_cnt_o = 64'd0;
`endif

endmodule

// File: tb/tb_inst_queue.sv
// -----------------------------------------------------------------------------
// tb_inst_queue
//
// Self-checking bench for inst_queue. A monitor keeps an instruction-level
// model. Every accepted line expands into the {pc, inst} pairs it must
// deliver. Each negedge the monitor compares the DUT's valid, stall, pc and
// instruction against that model. Scenario tasks drive stimulus and check the
// behaviour specific to each scenario.
// -----------------------------------------------------------------------------
module tb_inst_queue;

   localparam int DEPTH     = 4;
   localparam int LINE_SIZE = 512;

   logic                 clk;
   logic                 rst_n;
   logic                 icache_valid_i;
   logic [63:0]          icache_pc_i;
   logic [LINE_SIZE-1:0] icache_data_i;
   logic                 stall_icache_o;
   logic                 squash_pipe_i;
   logic                 iq_valid_o;
   logic                 iq_ready_i;
   logic [63:0]          iq_pc_o;
   logic [31:0]          iq_inst_o;
   logic [63:0]          perf_inst_cnt_o;
   logic [63:0]          perf_stall_cnt_o;

   int n_checks = 0;
   int n_fail   = 0;

   // Scoreboard: expected {pc, inst} per instruction, plus the number of
   // instructions still owed by each queued line.
   logic [95:0] exp_q[$];
   int          line_rem[$];
   logic [63:0] m_fires;
   logic [63:0] m_stalls;
   logic        m_valid;
   logic        m_full;
   logic [95:0] m_head;
   logic [63:0] m_pc;

   inst_queue #(.DEPTH(DEPTH), .LINE_SIZE(LINE_SIZE)) dut (
      .clk              (clk),
      .rst_n            (rst_n),
      .icache_valid_i   (icache_valid_i),
      .icache_pc_i      (icache_pc_i),
      .icache_data_i    (icache_data_i),
      .stall_icache_o   (stall_icache_o),
      .squash_pipe_i    (squash_pipe_i),
      .iq_valid_o       (iq_valid_o),
      .iq_ready_i       (iq_ready_i),
      .iq_pc_o          (iq_pc_o),
      .iq_inst_o        (iq_inst_o),
      .perf_inst_cnt_o  (perf_inst_cnt_o),
      .perf_stall_cnt_o (perf_stall_cnt_o)
   );

   // ---------------- clock / reset ----------------
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Inputs change 1 time unit after the rising edge.
   task automatic next_cycle();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [LINE_SIZE-1:0] rand_line();
      logic [LINE_SIZE-1:0] l;
      for (int i = 0; i < LINE_SIZE / 32; i++) l[32*i +: 32] = $urandom();
      return l;
   endfunction

   function automatic logic [63:0] exp_perf_inst();
`ifdef INST_QUEUE_PERF_EN
      return m_fires;
`else
      return 64'd0;
`endif
   endfunction

   function automatic logic [63:0] exp_perf_stall();
`ifdef INST_QUEUE_PERF_EN
      return m_stalls;
`else
      return 64'd0;
`endif
   endfunction

   // ---------------- scoreboard monitor ----------------
   initial begin
      m_fires  = '0;
      m_stalls = '0;
      forever begin
         @(negedge clk);
         if (!rst_n) begin
            exp_q.delete();
            line_rem.delete();
            m_fires  = '0;
            m_stalls = '0;
         end else begin
            m_valid = (exp_q.size() != 0);
            m_full  = (line_rem.size() == DEPTH);
            n_checks++;
            if (iq_valid_o !== m_valid) begin
               n_fail++;
               $display("FAIL sb_valid t=%0t got %b want %b", $time, iq_valid_o, m_valid);
            end
            n_checks++;
            if (stall_icache_o !== m_full) begin
               n_fail++;
               $display("FAIL sb_stall t=%0t got %b want %b", $time, stall_icache_o, m_full);
            end
            if (m_valid) begin
               m_head = exp_q[0];
               n_checks++;
               if (iq_pc_o !== m_head[95:32] || iq_inst_o !== m_head[31:0]) begin
                  n_fail++;
                  $display("FAIL sb_head t=%0t got pc %h inst %h want pc %h inst %h",
                           $time, iq_pc_o, iq_inst_o, m_head[95:32], m_head[31:0]);
               end
            end
            if (m_full) m_stalls = m_stalls + 64'd1;
            if (m_valid && iq_ready_i) m_fires = m_fires + 64'd1;
            if (squash_pipe_i) begin
               exp_q.delete();
               line_rem.delete();
            end else begin
               if (m_valid && iq_ready_i) begin
                  void'(exp_q.pop_front());
                  line_rem[0] = line_rem[0] - 1;
                  if (line_rem[0] == 0) void'(line_rem.pop_front());
               end
               if (icache_valid_i && !m_full) begin
                  for (int j = int'(icache_pc_i[5:2]); j < 16; j++) begin
                     m_pc = {icache_pc_i[63:6], 6'b0} + 64'(4 * j);
                     exp_q.push_back({m_pc, icache_data_i[32*j +: 32]});
                  end
                  line_rem.push_back(16 - int'(icache_pc_i[5:2]));
               end
            end
         end
      end
   end

   // ---------------- scenario tasks ----------------
   task automatic test_reset();
      repeat (3) @(posedge clk);
      #2;
      n_checks++;
      if (iq_valid_o !== 1'b0) begin n_fail++; $display("FAIL rst_valid got %b want 0", iq_valid_o); end
      n_checks++;
      if (stall_icache_o !== 1'b0) begin n_fail++; $display("FAIL rst_stall got %b want 0", stall_icache_o); end
      n_checks++;
      if (iq_pc_o !== 64'd0) begin n_fail++; $display("FAIL rst_pc got %h want 0", iq_pc_o); end
      n_checks++;
      if (perf_inst_cnt_o !== 64'd0 || perf_stall_cnt_o !== 64'd0) begin
         n_fail++;
         $display("FAIL rst_perf got %0d/%0d want 0/0", perf_inst_cnt_o, perf_stall_cnt_o);
      end
      next_cycle();
      rst_n = 1'b1;
      next_cycle();
      n_checks++;
      if (iq_valid_o !== 1'b0) begin n_fail++; $display("FAIL post_rst_valid got %b want 0", iq_valid_o); end
   endtask

   // Drains whatever is queued with ready held high and returns the number of
   // valid cycles seen. The wait is bounded.
   task automatic count_valid(input int limit, output int n_valid);
      n_valid = 0;
      for (int c = 0; c < limit; c++) begin
         if (iq_valid_o) n_valid++;
         @(posedge clk);
         #2;
      end
   endtask

   task automatic test_full_line();
      logic [LINE_SIZE-1:0] line;
      int n_valid;
      for (int i = 0; i < 16; i++) line[32*i +: 32] = 32'h100 + i;
      iq_ready_i = 1'b1;
      next_cycle();
      icache_valid_i = 1'b1;
      icache_pc_i    = 64'h1000;
      icache_data_i  = line;
      next_cycle();
      icache_valid_i = 1'b0;
      #1;
      n_checks++;
      if (iq_pc_o !== 64'h1000 || iq_inst_o !== 32'h100) begin
         n_fail++;
         $display("FAIL full_first got pc %h inst %h want pc 1000 inst 100", iq_pc_o, iq_inst_o);
      end
      for (int c = 0; c < 15; c++) begin
         @(posedge clk);
         #2;
      end
      n_checks++;
      if (iq_pc_o !== 64'h103C || iq_inst_o !== 32'h10F || iq_valid_o !== 1'b1) begin
         n_fail++;
         $display("FAIL full_last got v %b pc %h inst %h want v 1 pc 103c inst 10f",
                  iq_valid_o, iq_pc_o, iq_inst_o);
      end
      @(posedge clk);
      #2;
      n_checks++;
      if (iq_valid_o !== 1'b0) begin n_fail++; $display("FAIL full_empty got %b want 0", iq_valid_o); end
      count_valid(4, n_valid);
      n_checks++;
      if (n_valid != 0) begin n_fail++; $display("FAIL full_extra got %0d want 0", n_valid); end
   endtask

   task automatic test_offset();
      logic [LINE_SIZE-1:0] line;
      int n_valid;
      line = rand_line();
      iq_ready_i = 1'b1;
      next_cycle();
      icache_valid_i = 1'b1;
      icache_pc_i    = 64'h2038;
      icache_data_i  = line;
      next_cycle();
      icache_valid_i = 1'b0;
      #1;
      n_checks++;
      if (iq_pc_o !== 64'h2038 || iq_inst_o !== line[32*14 +: 32]) begin
         n_fail++;
         $display("FAIL offset_first got pc %h inst %h want pc 2038 inst %h",
                  iq_pc_o, iq_inst_o, line[32*14 +: 32]);
      end
      count_valid(8, n_valid);
      n_checks++;
      if (n_valid != 2) begin n_fail++; $display("FAIL offset_count got %0d want 2", n_valid); end
   endtask

   task automatic test_backpressure();
      logic [63:0] pcs [5];
      pcs[0] = 64'h303C; pcs[1] = 64'h3100; pcs[2] = 64'h3200;
      pcs[3] = 64'h3300; pcs[4] = 64'h3400;
      iq_ready_i = 1'b0;
      for (int l = 0; l < 4; l++) begin
         next_cycle();
         icache_valid_i = 1'b1;
         icache_pc_i    = pcs[l];
         icache_data_i  = rand_line();
      end
      // Fifth line offered and held for three stalled cycles.
      next_cycle();
      icache_pc_i   = pcs[4];
      icache_data_i = rand_line();
      for (int h = 0; h < 3; h++) begin
         if (h == 2) iq_ready_i = 1'b1;
         #1;
         n_checks++;
         if (stall_icache_o !== 1'b1) begin
            n_fail++;
            $display("FAIL bp_stall_hold%0d got %b want 1", h, stall_icache_o);
         end
         if (h < 2) next_cycle();
         else begin
            @(posedge clk);
            #1;
         end
      end
      // One fire popped the offset-15 line; the slot frees from this cycle.
      iq_ready_i = 1'b0;
      #1;
      n_checks++;
      if (stall_icache_o !== 1'b0) begin n_fail++; $display("FAIL bp_release got %b want 0", stall_icache_o); end
      next_cycle();
      icache_valid_i = 1'b0;
      #1;
      n_checks++;
      if (stall_icache_o !== 1'b1) begin n_fail++; $display("FAIL bp_refill got %b want 1", stall_icache_o); end
      n_checks++;
      if (perf_stall_cnt_o !== exp_perf_stall()) begin
         n_fail++;
         $display("FAIL bp_perf_stall got %0d want %0d", perf_stall_cnt_o, exp_perf_stall());
      end
      iq_ready_i = 1'b1;
      for (int c = 0; c < 200 && exp_q.size() != 0; c++) next_cycle();
      next_cycle();
      #1;
      n_checks++;
      if (exp_q.size() != 0 || iq_valid_o !== 1'b0) begin
         n_fail++;
         $display("FAIL bp_drain got left %0d valid %b want 0 0", exp_q.size(), iq_valid_o);
      end
   endtask

   task automatic test_squash();
      iq_ready_i = 1'b0;
      for (int l = 0; l < 3; l++) begin
         next_cycle();
         icache_valid_i = 1'b1;
         icache_pc_i    = 64'h4000 + 64'(l * 64);
         icache_data_i  = rand_line();
      end
      next_cycle();
      squash_pipe_i  = 1'b1;
      icache_pc_i    = 64'h4F00;
      icache_data_i  = rand_line();
      #1;
      n_checks++;
      if (iq_valid_o !== 1'b1) begin n_fail++; $display("FAIL sq_hold_valid got %b want 1", iq_valid_o); end
      next_cycle();
      squash_pipe_i  = 1'b0;
      icache_valid_i = 1'b0;
      #1;
      n_checks++;
      if (iq_valid_o !== 1'b0 || stall_icache_o !== 1'b0) begin
         n_fail++;
         $display("FAIL sq_empty got valid %b stall %b want 0 0", iq_valid_o, stall_icache_o);
      end
      iq_ready_i = 1'b1;
      repeat (3) next_cycle();
      #1;
      n_checks++;
      if (iq_valid_o !== 1'b0) begin n_fail++; $display("FAIL sq_no_store got %b want 0", iq_valid_o); end
      n_checks++;
      if (perf_inst_cnt_o !== exp_perf_inst()) begin
         n_fail++;
         $display("FAIL sq_perf_inst got %0d want %0d", perf_inst_cnt_o, exp_perf_inst());
      end
   endtask

   task automatic test_random();
      int n_lines = 12;
      int sent    = 0;
      logic acc;
      icache_valid_i = 1'b0;
      for (int cyc = 0; cyc < 4000 && (sent < n_lines || icache_valid_i || exp_q.size() != 0); cyc++) begin
         @(negedge clk);
         acc = icache_valid_i && !stall_icache_o;
         @(posedge clk);
         #1;
         if (acc) begin
            sent++;
            icache_valid_i = 1'b0;
         end
         if (!icache_valid_i && sent < n_lines && $urandom_range(0, 3) != 0) begin
            icache_valid_i = 1'b1;
            icache_pc_i    = {32'h0, $urandom()} & ~64'h3;
            icache_data_i  = rand_line();
         end
         iq_ready_i = 1'($urandom_range(0, 1));
      end
      iq_ready_i = 1'b0;
      next_cycle();
      #1;
      n_checks++;
      if (sent != n_lines || exp_q.size() != 0 || iq_valid_o !== 1'b0) begin
         n_fail++;
         $display("FAIL rnd_done got sent %0d left %0d valid %b want %0d 0 0",
                  sent, exp_q.size(), iq_valid_o, n_lines);
      end
      n_checks++;
      if (perf_inst_cnt_o !== exp_perf_inst()) begin
         n_fail++;
         $display("FAIL rnd_perf_inst got %0d want %0d", perf_inst_cnt_o, exp_perf_inst());
      end
   endtask

   task automatic test_reset_mid();
      logic [LINE_SIZE-1:0] line;
      int n_valid;
      iq_ready_i = 1'b0;
      for (int l = 0; l < 4; l++) begin
         next_cycle();
         icache_valid_i = 1'b1;
         icache_pc_i    = 64'h6000 + 64'(l * 64);
         icache_data_i  = rand_line();
      end
      next_cycle();
      icache_valid_i = 1'b0;
      iq_ready_i     = 1'b1;
      repeat (2) next_cycle();
      #1;
      n_checks++;
      if (iq_valid_o !== 1'b1 || stall_icache_o !== 1'b1) begin
         n_fail++;
         $display("FAIL mid_pre got valid %b stall %b want 1 1", iq_valid_o, stall_icache_o);
      end
      rst_n = 1'b0;
      #1;
      n_checks++;
      if (iq_valid_o !== 1'b0 || stall_icache_o !== 1'b0 || iq_pc_o !== 64'd0) begin
         n_fail++;
         $display("FAIL mid_async got valid %b stall %b pc %h want 0 0 0", iq_valid_o, stall_icache_o, iq_pc_o);
      end
      n_checks++;
      if (perf_inst_cnt_o !== 64'd0 || perf_stall_cnt_o !== 64'd0) begin
         n_fail++;
         $display("FAIL mid_perf got %0d/%0d want 0/0", perf_inst_cnt_o, perf_stall_cnt_o);
      end
      repeat (2) next_cycle();
      rst_n = 1'b1;
      line  = rand_line();
      next_cycle();
      icache_valid_i = 1'b1;
      icache_pc_i    = 64'h5004;
      icache_data_i  = line;
      next_cycle();
      icache_valid_i = 1'b0;
      #1;
      count_valid(24, n_valid);
      n_checks++;
      if (n_valid != 15) begin n_fail++; $display("FAIL mid_resume got %0d want 15", n_valid); end
   endtask

   // ---------------- main sequence ----------------
   initial begin
      rst_n          = 1'b0;
      icache_valid_i = 1'b0;
      icache_pc_i    = '0;
      icache_data_i  = '0;
      squash_pipe_i  = 1'b0;
      iq_ready_i     = 1'b0;
      test_reset();
      test_full_line();
      test_offset();
      test_backpressure();
      test_squash();
      test_random();
      test_reset_mid();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/inst_queue.md
INST_QUEUE -- requirements
Module: inst_queue

Interface
REQ-001 Parameter: DEPTH, 4, number of cache-line entries; SHALL be a power of two, >= 2.
REQ-002 Parameter: LINE_SIZE, 512, line width in bits, i.e. 16 x 32-bit instruction words.
REQ-003 Port: clk  input  1  clock; all state updates on the rising edge.
REQ-004 Port: rst_n  input  1  reset, asynchronous, active-low.
REQ-005 Port: icache_valid_i  input  1  fetched line valid from icache.
REQ-006 Port: icache_pc_i  input  64  fetch pc of the line.
REQ-007 Port: icache_data_i  input  512  cache line data.
REQ-008 Port: stall_icache_o  output  1  backpressure to icache.
REQ-009 Port: squash_pipe_i  input  1  backend flush.
REQ-010 Port: iq_valid_o  output  1  instruction valid to decode.
REQ-011 Port: iq_ready_i  input  1  decode accepts instruction.
REQ-012 Port: iq_pc_o  output  64  pc of the presented instruction.
REQ-013 Port: iq_inst_o  output  32  presented instruction.
REQ-014 Port: perf_inst_cnt_o  output  64  instructions delivered (REQ-035).
REQ-015 Port: perf_stall_cnt_o  output  64  cycles with stall_icache_o high (REQ-035).

Function
REQ-016 Storage SHALL be a circular FIFO of DEPTH entries; each entry holds {pc[63:0], line[511:0]}, with a read pointer, a write pointer and a count of width log2(DEPTH)+1.
REQ-017 stall_icache_o SHALL equal (count == DEPTH), derived from registered state only, with no combinational path from any input.
REQ-018 Push SHALL occur when icache_valid_i && !stall_icache_o && !squash_pipe_i; the entry stores icache_pc_i with bits [1:0] forced to 0.
REQ-019 A line presented while stall_icache_o is high SHALL be discarded, so a line held by the stalled icache is accepted exactly once.
REQ-020 iq_valid_o SHALL equal (count != 0); a push is visible on the outputs no earlier than the next cycle (no bypass).
REQ-021 iq_pc_o SHALL equal the head entry pc, and iq_inst_o SHALL equal head line[32*pc[5:2] +: 32].
REQ-022 Fire is iq_valid_o && iq_ready_i.
REQ-023 On fire with head pc[5:2] != 15: the head pc SHALL advance by 4 in place and the entry is retained.
REQ-024 On fire with head pc[5:2] == 15: the head entry SHALL pop and the read pointer increments modulo DEPTH.
REQ-025 A line entered at word offset k SHALL deliver exactly 16-k instructions in order.
REQ-026 Simultaneous push and pop SHALL leave count unchanged; both pointers wrap modulo DEPTH independently.
REQ-027 A push is impossible when full (REQ-017), so a pop in the same cycle does not release a slot until the next cycle.
REQ-028 squash_pipe_i SHALL, at the next edge, set count, read pointer and write pointer to 0; squash has priority over push and fire in the same cycle.
REQ-029 While squash_pipe_i is high, outputs SHALL still reflect the current registered state; decode qualifies them with squash.
REQ-030 iq_valid_o SHALL drop to 0 in the cycle after a squash.
REQ-031 Line data SHALL need no reset; pointers, count and entry pcs are reset.

Reset
REQ-032 While rst_n is low: count, pointers and entry pcs SHALL be 0; iq_valid_o = 0, stall_icache_o = 0, iq_pc_o = 0, perf counters = 0.
REQ-033 A reset asserted mid-operation SHALL discard all queued lines immediately (asynchronous).
REQ-034 Reset deassertion SHALL be followed by normal operation from the next rising edge.

Configuration
REQ-035 With macro INST_QUEUE_PERF_EN defined:
  - perf_inst_cnt_o SHALL increment by 1 on every fire.
  - perf_stall_cnt_o SHALL increment by 1 every cycle stall_icache_o is high.
  - Both counters wrap at 2^64, are not cleared by squash, and are cleared only by reset.
REQ-036 Without INST_QUEUE_PERF_EN: both perf ports SHALL be tied to constant 0 and no counter registers are built.

Verification
REQ-037 Push pc 0x1000 with line words w = 0x100+i, iq_ready_i = 1 -> 16 instructions over 16 consecutive cycles, pc 0x1000..0x103C, inst 0x100..0x10F, then iq_valid_o = 0.
REQ-038 Push pc 0x2038 -> exactly two instructions (pc 0x2038 and 0x203C, words 14 and 15), then entry pops.
REQ-039 iq_ready_i = 0 with continuous icache_valid_i -> stall_icache_o high after 4 pushes; a 5th line held for 3 cycles is accepted once after the first pop.
REQ-040 Queue holding 3 lines, squash_pipe_i for 1 cycle with concurrent icache_valid_i -> next cycle count = 0, iq_valid_o = 0, and the concurrent line is not stored.
REQ-041 Run 8+ lines through with random iq_ready_i -> pointers wrap, order preserved, no duplicate or lost instruction; with INST_QUEUE_PERF_EN, perf_inst_cnt_o equals total fires.
REQ-042 Assert rst_n low mid-drain -> iq_valid_o = 0 and stall_icache_o = 0 asynchronously.
